// File: rtl/ocupacion_pkg.sv
// rtl/ocupacion_pkg.sv - shared scan states, glyph constants and lookup for the occupancy display
package ocupacion_pkg;

  // Scan order is GAP0 -> D0_ON -> GAP1 -> D1_ON -> GAP0
  typedef enum logic [1:0] {
    GAP0  = 2'd0,
    D0_ON = 2'd1,
    GAP1  = 2'd2,
    D1_ON = 2'd3
  } scan_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  function automatic logic [6:0] glyph(input logic [2:0] v);
    case (v)
      3'd0:    glyph = GLYPH_0;
      3'd1:    glyph = GLYPH_1;
      3'd2:    glyph = GLYPH_2;
      3'd3:    glyph = GLYPH_3;
      3'd4:    glyph = GLYPH_4;
      3'd5:    glyph = GLYPH_5;
      3'd6:    glyph = GLYPH_6;
      default: glyph = GLYPH_7;
    endcase
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// rtl/divisor_tick.sv - free-running modulo-N counter with a one-cycle tick on its last count
module divisor_tick #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  // Count 0..N-1; clr holds the counter at 0 so the next period starts cleanly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/display_ocupacion.sv
// rtl/display_ocupacion.sv - 2-digit multiplexed occupied/free display with full/empty flags and full blink
module display_ocupacion #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_HZ   = 2,
  parameter int GAP_CYC    = 4,
  parameter int CAPACITY   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       full,
  output logic       empty
);

  import ocupacion_pkg::*;

  localparam int DIV  = CLK_HZ / REFRESH_HZ;
  localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [2:0]    CAP      = 3'(CAPACITY);

  scan_state_t   state, state_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          gap_last;
  logic [2:0]    occ;
  logic [2:0]    free;
  logic          slot_clr, slot_tick;
  logic          blink_tick, blink_ph, blink_n;
  logic [6:0]    seg_n;
  logic [1:0]    an_n;

  // Clamp keeps free spaces from ever wrapping below zero
  assign free     = CAP - occ;
  assign gap_last = (gap_cnt == GAP_LAST);
  assign slot_clr = (state == GAP0) || (state == GAP1);

  divisor_tick #(.N(DIV)) u_slot (
    .clk  (clk),
    .rst  (rst),
    .clr  (slot_clr),
    .tick (slot_tick)
  );

  divisor_tick #(.N(BDIV)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .clr  (!full),
    .tick (blink_tick)
  );

  // Input register with clamp to lot capacity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= 3'd0;
    end else begin
      occ <= (count > CAP) ? CAP : count;
    end
  end

  // Flags registered from the clamped occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      full  <= (occ == CAP);
      empty <= (occ == 3'd0);
    end
  end

  // Next scan state, slot latch value, blink phase and anode pattern
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    seg_n   = seg;
    case (state)
      GAP0, GAP1: begin
        if (gap_last) begin
          gap_n   = '0;
          state_n = (state == GAP0) ? D0_ON : D1_ON;
          // F is chosen from occ directly so it tracks the same value as the free digit
          if (state == GAP0) begin
            seg_n = glyph(occ);
          end else begin
            seg_n = (occ == CAP) ? GLYPH_F : glyph(free);
          end
        end else begin
          gap_n = gap_cnt + GW'(1);
          seg_n = GLYPH_BLANK;
        end
      end
      D0_ON: begin
        if (slot_tick) begin
          state_n = GAP1;
          seg_n   = GLYPH_BLANK;
        end
      end
      D1_ON: begin
        if (slot_tick) begin
          state_n = GAP0;
          seg_n   = GLYPH_BLANK;
        end
      end
      default: begin
        state_n = GAP0;
        seg_n   = GLYPH_BLANK;
      end
    endcase

    blink_n = full && (blink_tick ? !blink_ph : blink_ph);

    an_n = 2'b11;
    if (!blink_n) begin
      if (state_n == D0_ON) an_n = 2'b10;
      if (state_n == D1_ON) an_n = 2'b01;
    end
  end

  // Scan FSM with registered outputs; resets into GAP0 so the first lit slot is digit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= GAP0;
      gap_cnt  <= '0;
      blink_ph <= 1'b0;
      seg      <= GLYPH_BLANK;
      an       <= 2'b11;
    end else begin
      state    <= state_n;
      gap_cnt  <= gap_n;
      blink_ph <= blink_n;
      seg      <= seg_n;
      an       <= an_n;
    end
  end

endmodule

// File: tb/tb_display_ocupacion.sv
// tb/tb_display_ocupacion.sv - self-checking bench for display_ocupacion
module tb_display_ocupacion;

  localparam int DIV = 10;
  localparam logic [6:0] G_F   = 7'b0001110;
  localparam logic [6:0] BLANK = 7'h7F;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;
  logic [2:0] count5;
  logic [6:0] seg, seg5;
  logic [1:0] an, an5;
  logic       full, empty, full5, empty5;

  int checks = 0;
  int passed = 0;

  logic [6:0] gl [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
  } slot_t;

  slot_t exp_q[$];

  always #5 clk = ~clk;

  display_ocupacion #(
    .CLK_HZ(1000), .REFRESH_HZ(100), .BLINK_HZ(25), .GAP_CYC(2), .CAPACITY(7)
  ) dut (
    .clk(clk), .rst(rst), .count(count), .seg(seg), .an(an), .full(full), .empty(empty)
  );

  display_ocupacion #(
    .CLK_HZ(1000), .REFRESH_HZ(100), .BLINK_HZ(25), .GAP_CYC(2), .CAPACITY(5)
  ) dut5 (
    .clk(clk), .rst(rst), .count(count5), .seg(seg5), .an(an5), .full(full5), .empty(empty5)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1);
    exp_q.push_back('{an: 2'b10, seg: s0});
    exp_q.push_back('{an: 2'b01, seg: s1});
  endtask

  task automatic consume_slot(input string name, input int change_at, input logic [2:0] new_count);
    slot_t      e;
    int         waited;
    logic       bad;
    logic [1:0] a_bad;
    logic [6:0] s_bad;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, no expected slot", name);
      return;
    end
    e = exp_q.pop_front();
    waited = 0;
    while (an === 2'b11 && waited < 40) begin
      step();
      waited++;
    end
    if (an === 2'b11) begin
      $display("FAIL %s: no digit slot within 40 cycles, an=%b required an=%b", name, an, e.an);
      return;
    end
    bad = 1'b0;
    a_bad = an;
    s_bad = seg;
    for (int i = 0; i < DIV; i++) begin
      if (!bad && (an !== e.an || seg !== e.seg)) begin
        bad = 1'b1; a_bad = an; s_bad = seg;
      end
      if (i == change_at) count = new_count;
      step();
    end
    if (!bad && an !== 2'b11) begin
      bad = 1'b1; a_bad = an; s_bad = seg;
    end
    if (bad) $display("FAIL %s: an=%b seg=%h, required an=%b seg=%h for %0d cycles then an=11",
                      name, a_bad, s_bad, e.an, e.seg, DIV);
    else passed++;
  endtask

  task automatic wait_d1_end(input string name);
    int n = 0;
    while (an !== 2'b01 && n < 100) begin step(); n++; end
    while (an === 2'b01 && n < 100) begin step(); n++; end
    if (n >= 100) begin
      checks++;
      $display("FAIL %s: digit 1 slot not seen within 100 cycles, an=%b", name, an);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    count = 3'd0;
    repeat (5) step();
    checks++; if (an !== 2'b11) $display("FAIL reset_an: an=%b required 11", an); else passed++;
    checks++; if (seg !== BLANK) $display("FAIL reset_seg: seg=%h required %h", seg, BLANK); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty: empty=%b required 1", empty); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full: full=%b required 0", full); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (an !== 2'b11 || seg !== BLANK) $display("FAIL reset_gap1: an=%b seg=%h required 11/%h", an, seg, BLANK); else passed++;
    step();
    checks++; if (an !== 2'b11 || seg !== BLANK) $display("FAIL reset_gap2: an=%b seg=%h required 11/%h", an, seg, BLANK); else passed++;
    step();
    checks++; if (an !== 2'b10) $display("FAIL reset_d0_start: an=%b required 10", an); else passed++;
    push_frame(gl[0], gl[7]);
    consume_slot("reset_d0", -1, 3'd0);
    consume_slot("reset_d1", -1, 3'd0);
  endtask

  task automatic test_mid_range();
    count = 3'd3;
    step();
    checks++; if (empty !== 1'b1) $display("FAIL mid_empty_lat1: empty=%b required 1", empty); else passed++;
    step();
    checks++; if (empty !== 1'b0 || full !== 1'b0) $display("FAIL mid_flags_lat2: empty=%b full=%b required 0/0", empty, full); else passed++;
    wait_d1_end("mid_sync");
    push_frame(gl[3], gl[4]);
    consume_slot("mid_d0", -1, 3'd0);
    consume_slot("mid_d1", -1, 3'd0);
  endtask

  task automatic test_mid_slot();
    count = 3'd2;
    wait_d1_end("midslot_sync");
    push_frame(gl[2], gl[2]);
    push_frame(gl[5], gl[2]);
    consume_slot("midslot_d0_hold", 3, 3'd5);
    consume_slot("midslot_d1", -1, 3'd0);
    consume_slot("midslot_next_d0", -1, 3'd0);
    consume_slot("midslot_next_d1", -1, 3'd0);
  endtask

  task automatic test_full_blink();
    int   blank_run = 0, on_run = 0, max_blank = 0, max_on = 0;
    logic bad_seg = 1'b0, saw_d1 = 1'b0;
    logic [1:0] a_bad = 2'b00;
    logic [6:0] s_bad = 7'h00;
    count = 3'd7;
    step();
    checks++; if (full !== 1'b0) $display("FAIL full_lat1: full=%b required 0", full); else passed++;
    step();
    checks++; if (full !== 1'b1 || empty !== 1'b0) $display("FAIL full_lat2: full=%b empty=%b required 1/0", full, empty); else passed++;
    repeat (25) step();
    for (int i = 0; i < 100; i++) begin
      if (an === 2'b11) begin blank_run++; on_run = 0; end
      else begin on_run++; blank_run = 0; end
      if (blank_run > max_blank) max_blank = blank_run;
      if (on_run > max_on) max_on = on_run;
      if (an === 2'b01) begin
        saw_d1 = 1'b1;
        if (seg !== G_F && !bad_seg) begin bad_seg = 1'b1; a_bad = an; s_bad = seg; end
      end
      if (an === 2'b10 && seg !== gl[7] && !bad_seg) begin bad_seg = 1'b1; a_bad = an; s_bad = seg; end
      step();
    end
    checks++; if (bad_seg) $display("FAIL full_glyphs: an=%b seg=%h required D1 %h / D0 %h", a_bad, s_bad, G_F, gl[7]); else passed++;
    checks++; if (!saw_d1) $display("FAIL full_d1_visible: digit 1 never lit in 100 cycles, required at least once"); else passed++;
    checks++; if (max_blank < 20 || max_blank > 24) $display("FAIL blink_off_window: longest blank run=%0d required 20..24", max_blank); else passed++;
    checks++; if (max_on < 1 || max_on > DIV) $display("FAIL blink_on_run: longest lit run=%0d required 1..%0d", max_on, DIV); else passed++;
    count = 3'd6;
    step();
    checks++; if (full !== 1'b1) $display("FAIL unfull_lat1: full=%b required 1", full); else passed++;
    step();
    checks++; if (full !== 1'b0) $display("FAIL unfull_lat2: full=%b required 0", full); else passed++;
    wait_d1_end("unfull_sync");
    push_frame(gl[6], gl[1]);
    consume_slot("unfull_d0", -1, 3'd0);
    consume_slot("unfull_d1", -1, 3'd0);
  endtask

  task automatic test_clamp();
    logic bad = 1'b0, saw0 = 1'b0, saw1 = 1'b0;
    logic [1:0] a_bad = 2'b00;
    logic [6:0] s_bad = 7'h00;
    checks++; if (full5 !== 1'b1 || empty5 !== 1'b0) $display("FAIL clamp_flags: full=%b empty=%b required 1/0", full5, empty5); else passed++;
    for (int i = 0; i < 100; i++) begin
      if (an5 === 2'b10) begin
        saw0 = 1'b1;
        if (seg5 !== gl[5] && !bad) begin bad = 1'b1; a_bad = an5; s_bad = seg5; end
      end else if (an5 === 2'b01) begin
        saw1 = 1'b1;
        if (seg5 !== G_F && !bad) begin bad = 1'b1; a_bad = an5; s_bad = seg5; end
      end else if (an5 !== 2'b11 && !bad) begin
        bad = 1'b1; a_bad = an5; s_bad = seg5;
      end
      step();
    end
    checks++; if (bad) $display("FAIL clamp_glyphs: an=%b seg=%h required D0 %h / D1 %h", a_bad, s_bad, gl[5], G_F); else passed++;
    checks++; if (!(saw0 && saw1)) $display("FAIL clamp_visible: saw_d0=%b saw_d1=%b required 1/1", saw0, saw1); else passed++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    count = 3'd4;
    wait_d1_end("rstmid_settle");
    while (an !== 2'b01 && n < 100) begin step(); n++; end
    checks++; if (an !== 2'b01) $display("FAIL rstmid_find_d1: an=%b required 01", an); else passed++;
    repeat (3) step();
    rst = 1'b1;
    #1;
    checks++; if (an !== 2'b11 || seg !== BLANK) $display("FAIL rstmid_async: an=%b seg=%h required 11/%h", an, seg, BLANK); else passed++;
    checks++; if (full !== 1'b0 || empty !== 1'b1) $display("FAIL rstmid_flags: full=%b empty=%b required 0/1", full, empty); else passed++;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (an !== 2'b11) $display("FAIL rstmid_gap1: an=%b required 11", an); else passed++;
    step();
    checks++; if (an !== 2'b11) $display("FAIL rstmid_gap2: an=%b required 11", an); else passed++;
    step();
    checks++; if (an !== 2'b10) $display("FAIL rstmid_d0_start: an=%b required 10", an); else passed++;
    push_frame(gl[4], gl[3]);
    consume_slot("rstmid_d0", -1, 3'd0);
    consume_slot("rstmid_d1", -1, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    count5 = 3'd6;
    test_reset();
    test_mid_range();
    test_mid_slot();
    test_full_blink();
    test_clamp();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
